// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types and widths for the APB completers behind the AHB-to-APB bridge
package bridge_pkg;
   localparam int APB_DATA_W = 32;
   localparam int APB_ADDR_W = 32;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_slv_state_e;
endpackage

// File: rtl/apb_slv_regfile.sv
// apb_slv_regfile: DEPTH x 32 register array, cleared by reset
// Ports: HCLK/HRESET_n clock and async active-low reset; we/widx/wdata write port;
//        ridx/rdata combinational read port.
module apb_slv_regfile
   import bridge_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IW    = 4
) (
   input  logic                  HCLK,
   input  logic                  HRESET_n,
   input  logic                  we,
   input  logic [IW-1:0]         widx,
   input  logic [APB_DATA_W-1:0] wdata,
   input  logic [IW-1:0]         ridx,
   output logic [APB_DATA_W-1:0] rdata
);
   logic [APB_DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge HCLK or negedge HRESET_n)
      if (!HRESET_n)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (we)
         mem[widx] <= wdata;
   assign rdata = mem[ridx];
endmodule

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB3 completer with a register bank and a fixed number of wait states
// Ports: HCLK/HRESET_n clock and async active-low reset; PSELx/PENABLE/PWRITE/PADDR/PWDATA
//        request from the bridge; PRDATA/PREADY/PSLVERR registered response.
module apb_wait_slave
   import bridge_pkg::*;
#(
   parameter int                    DEPTH       = 16,
   parameter int                    WAIT_CYCLES = 2,
   parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                  HCLK,
   input  logic                  HRESET_n,
   input  logic                  PSELx,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [APB_ADDR_W-1:0] PADDR,
   input  logic [APB_DATA_W-1:0] PWDATA,
   output logic [APB_DATA_W-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   apb_slv_state_e        state;
   logic [3:0]            cnt;
   logic [IW-1:0]         idx;
   logic                  wr;
   logic                  ok;
   logic [APB_DATA_W-1:0] wd;
   logic                  setup;
   logic                  go_done;
   logic                  we;
   logic                  a_ok;
   logic                  d_ok;
   logic                  d_wr;
   logic [29:0]           woff;
   logic [IW-1:0]         ridx;
   logic [APB_DATA_W-1:0] rdata;
   assign setup   = PSELx && !PENABLE && state != WAIT;
   assign woff    = 30'((PADDR - BASE_ADDR) >> 2);
   assign a_ok    = PADDR >= BASE_ADDR && woff < 30'(DEPTH);
   assign go_done = setup ? WAIT_CYCLES == 0 : state == WAIT && PSELx && cnt == 4'd0;
   // With zero wait states DONE is entered on the setup edge, before the latched copies exist
   assign d_ok    = setup ? a_ok : ok;
   assign d_wr    = setup ? PWRITE : wr;
   assign ridx    = setup ? woff[IW-1:0] : idx;
   assign we      = state == DONE && PSELx && PENABLE && ok && wr;
   apb_slv_regfile #(.DEPTH(DEPTH), .IW(IW)) u_regfile (
      .HCLK    (HCLK),
      .HRESET_n(HRESET_n),
      .we      (we),
      .widx    (idx),
      .wdata   (wd),
      .ridx    (ridx),
      .rdata   (rdata)
   );
   always_ff @(posedge HCLK or negedge HRESET_n)
      if (!HRESET_n) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         wr      <= 1'b0;
         ok      <= 1'b0;
         wd      <= '0;
         PRDATA  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
      end else begin
         PREADY  <= go_done;
         PSLVERR <= go_done && !d_ok;
         PRDATA  <= go_done && d_ok && !d_wr ? rdata : '0;
         if (setup) begin
            idx   <= woff[IW-1:0];
            wr    <= PWRITE;
            ok    <= a_ok;
            wd    <= PWDATA;
            state <= WAIT_CYCLES == 0 ? DONE : WAIT;
            cnt   <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
         end else if (state == WAIT && PSELx) begin
            state <= cnt == 4'd0 ? DONE : WAIT;
            cnt   <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
         end else
            state <= IDLE;
      end
endmodule

// File: tb/tb_apb_wait_slave.sv
// tb_apb_wait_slave: directed tests for apb_wait_slave with 2 and 0 wait states
module tb_apb_wait_slave;
   logic        HCLK = 1'b0;
   logic        HRESET_n = 1'b0;
   logic        PSELx = 1'b0;
   logic        psel0 = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [31:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA, PRDATA0;
   logic        PREADY, PREADY0, PSLVERR, PSLVERR0;
   int          checks = 0;
   int          fails = 0;

   apb_wait_slave #(.DEPTH(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
      .HCLK(HCLK), .HRESET_n(HRESET_n), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

   apb_wait_slave #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
      .HCLK(HCLK), .HRESET_n(HRESET_n), .PSELx(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA0), .PREADY(PREADY0), .PSLVERR(PSLVERR0));

   always #5 HCLK = ~HCLK;

   task automatic cyc;
      @(posedge HCLK);
      #1;
   endtask

   // One complete transfer; lat is the cycle index (setup = 0) in which PREADY was seen
   task automatic apb(input bit z, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int lat, output logic after);
      if (z) psel0 = 1'b1; else PSELx = 1'b1;
      PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
      cyc();
      PENABLE = 1'b1;
      lat = 1;
      while ((z ? PREADY0 : PREADY) !== 1'b1 && lat < 20) begin cyc(); lat++; end
      rd  = z ? PRDATA0 : PRDATA;
      err = z ? PSLVERR0 : PSLVERR;
      cyc();
      after = z ? PREADY0 : PREADY;
      PSELx = 1'b0; psel0 = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] rd; logic err, after; int lat;
      HRESET_n = 1'b0;
      repeat (3) cyc();
      checks++; if ({PRDATA, PREADY, PSLVERR} !== 34'h0) begin fails++; $display("FAIL reset_held dut: got %h expected 0", {PRDATA, PREADY, PSLVERR}); end
      checks++; if ({PRDATA0, PREADY0, PSLVERR0} !== 34'h0) begin fails++; $display("FAIL reset_held dut0: got %h expected 0", {PRDATA0, PREADY0, PSLVERR0}); end
      HRESET_n = 1'b1;
      cyc();
      checks++; if ({PRDATA, PREADY, PSLVERR} !== 34'h0) begin fails++; $display("FAIL reset_idle: got %h expected 0", {PRDATA, PREADY, PSLVERR}); end
      apb(0, 0, 32'h04, 32'h0, rd, err, lat, after);
      checks++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_read_data: got %h expected 00000000", rd); end
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_read_err: got %b expected 0", err); end
      checks++; if (lat !== 3) begin fails++; $display("FAIL reset_read_lat: got %0d expected 3", lat); end
   endtask

   task automatic test_wait2;
      logic [31:0] rd; logic err, after; int lat;
      apb(0, 1, 32'h08, 32'hDEAD_BEEF, rd, err, lat, after);
      checks++; if (lat !== 3) begin fails++; $display("FAIL w2_write_lat: got %0d expected 3", lat); end
      checks++; if (after !== 1'b0) begin fails++; $display("FAIL w2_write_ready_width: got %b expected 0", after); end
      checks++; if ({err, rd} !== 33'h0) begin fails++; $display("FAIL w2_write_resp: got %h expected 0", {err, rd}); end
      apb(0, 0, 32'h08, 32'h0, rd, err, lat, after);
      checks++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL w2_read_data: got %h expected deadbeef", rd); end
      checks++; if (lat !== 3) begin fails++; $display("FAIL w2_read_lat: got %0d expected 3", lat); end
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL w2_read_err: got %b expected 0", err); end
      checks++; if (after !== 1'b0) begin fails++; $display("FAIL w2_read_ready_width: got %b expected 0", after); end
   endtask

   task automatic test_zero_wait;
      logic [31:0] rd0, rd1; logic err, after; int lat0, lat1, lat2, lat3;
      apb(1, 1, 32'h00, 32'h11, rd0, err, lat0, after);
      apb(1, 1, 32'h04, 32'h22, rd0, err, lat1, after);
      apb(1, 0, 32'h00, 32'h0, rd0, err, lat2, after);
      apb(1, 0, 32'h04, 32'h0, rd1, err, lat3, after);
      checks++; if ({lat0, lat1, lat2, lat3} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin fails++; $display("FAIL z_lat: got %0d %0d %0d %0d expected 1 1 1 1", lat0, lat1, lat2, lat3); end
      checks++; if (rd0 !== 32'h11) begin fails++; $display("FAIL z_read0: got %h expected 00000011", rd0); end
      checks++; if (rd1 !== 32'h22) begin fails++; $display("FAIL z_read1: got %h expected 00000022", rd1); end
      checks++; if ({err, after} !== 2'b00) begin fails++; $display("FAIL z_last_resp: got %b expected 00", {err, after}); end
   endtask

   task automatic test_out_of_range;
      logic [31:0] rd; logic err, after; int lat;
      apb(0, 1, 32'h00, 32'h1234, rd, err, lat, after);
      apb(0, 1, 32'h40, 32'h55, rd, err, lat, after);
      checks++; if (lat !== 3) begin fails++; $display("FAIL oor_write_lat: got %0d expected 3", lat); end
      checks++; if (err !== 1'b1) begin fails++; $display("FAIL oor_write_err: got %b expected 1", err); end
      apb(0, 0, 32'h40, 32'h0, rd, err, lat, after);
      checks++; if (rd !== 32'h0) begin fails++; $display("FAIL oor_read_data: got %h expected 00000000", rd); end
      checks++; if (err !== 1'b1) begin fails++; $display("FAIL oor_read_err: got %b expected 1", err); end
      apb(0, 0, 32'h00, 32'h0, rd, err, lat, after);
      checks++; if (rd !== 32'h1234) begin fails++; $display("FAIL oor_reg0_kept: got %h expected 00001234", rd); end
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL oor_reg0_err: got %b expected 0", err); end
   endtask

   task automatic test_abort;
      logic [31:0] rd; logic err, after; int lat; int seen;
      apb(0, 1, 32'h0C, 32'h1111, rd, err, lat, after);
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'hAAAA;
      cyc();
      PENABLE = 1'b1;
      seen = int'(PREADY);
      cyc();
      seen += int'(PREADY);
      PSELx = 1'b0; PENABLE = 1'b0;
      repeat (4) begin cyc(); seen += int'(PREADY); end
      checks++; if (seen !== 0) begin fails++; $display("FAIL abort_no_ready: got %0d ready cycles expected 0", seen); end
      PENABLE = 1'b1;
      repeat (2) begin cyc(); seen += int'(PREADY); end
      PENABLE = 1'b0;
      checks++; if (seen !== 0) begin fails++; $display("FAIL idle_enable_ignored: got %0d ready cycles expected 0", seen); end
      apb(0, 0, 32'h0C, 32'h0, rd, err, lat, after);
      checks++; if (rd !== 32'h1111) begin fails++; $display("FAIL abort_read: got %h expected 00001111", rd); end
      checks++; if (lat !== 3) begin fails++; $display("FAIL abort_read_lat: got %0d expected 3", lat); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd; logic err, after; int lat;
      apb(0, 1, 32'h10, 32'h77, rd, err, lat, after);
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h10;
      cyc(); PENABLE = 1'b1;
      cyc(); cyc();
      checks++; if ({PREADY, PRDATA} !== {1'b1, 32'h77}) begin fails++; $display("FAIL mid_done_resp: got %h expected 100000077", {PREADY, PRDATA}); end
      #2 HRESET_n = 1'b0;
      #1;
      checks++; if ({PRDATA, PREADY, PSLVERR} !== 34'h0) begin fails++; $display("FAIL mid_async_clear: got %h expected 0", {PRDATA, PREADY, PSLVERR}); end
      PSELx = 1'b0; PENABLE = 1'b0;
      cyc(); HRESET_n = 1'b1; cyc();
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'hCAFE;
      cyc(); PENABLE = 1'b1;
      #2 HRESET_n = 1'b0;
      #1;
      checks++; if ({PRDATA, PREADY, PSLVERR} !== 34'h0) begin fails++; $display("FAIL mid_wait_clear: got %h expected 0", {PRDATA, PREADY, PSLVERR}); end
      cyc(); cyc();
      PSELx = 1'b0; PENABLE = 1'b0;
      HRESET_n = 1'b1;
      cyc();
      apb(0, 0, 32'h10, 32'h0, rd, err, lat, after);
      checks++; if (rd !== 32'h0) begin fails++; $display("FAIL mid_read_cleared: got %h expected 00000000", rd); end
      checks++; if (lat !== 3) begin fails++; $display("FAIL mid_read_lat: got %0d expected 3", lat); end
   endtask

   initial begin
      test_reset();
      test_wait2();
      test_zero_wait();
      test_out_of_range();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
